// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB command master.
// Optional abort-on-stall logic is enabled with APB_MASTER_TIMEOUT_EN.
package apb_master_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RDATA  = 2'd3;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/apb_master_if.sv
// Client command/response and APB bus signals of the APB master.
// master modport is the apb_master view; slave is the far side.
interface apb_master_if
    import apb_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata, pready,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata, pready,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit
// so full and empty are told apart without a counter.
module apb_cmd_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// FIFO-buffered APB requester, one transfer at a time.
// Define APB_MASTER_TIMEOUT_EN to abort transfers stalled in ACCESS.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic          pclk,
    input  logic          preset,
    apb_master_if.master  bus
);
    localparam int CW = 1 + ADDR_W + DATA_W;

    if (FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_master: bad FIFO_DEPTH/TIMEOUT_CYCLES");
    end

    logic [1:0]    state;
    logic [CW-1:0] head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          done;
    logic          expire;

    apb_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (bus.cmd_valid),
        .wdata ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.cmd_ready = !full;
    assign bus.psel      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign bus.penable   = (state == ST_ACCESS);
    assign done          = (state == ST_ACCESS) && bus.pready;

    // Writes chain straight into the next SETUP; reads go via RDATA first.
    assign pop = !empty && ((state == ST_IDLE) ||
                            (state == ST_RDATA) ||
                            (done && bus.pwrite));

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;

    assign expire = (state == ST_ACCESS) && !bus.pready &&
                    (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk) begin
        if (preset || state != ST_ACCESS) begin
            timer <= '0;
        end else if (!bus.pready) begin
            timer <= timer + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state         <= ST_IDLE;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= '0;
            bus.pwdata    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            if (pop) begin
                {bus.pwrite, bus.paddr, bus.pwdata} <= head;
            end
            case (state)
                ST_IDLE: begin
                    if (!empty) state <= ST_SETUP;
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done && bus.pwrite) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_write <= 1'b1;
                        bus.rsp_rdata <= '0;
                        state <= empty ? ST_IDLE : ST_SETUP;
                    end else if (done) begin
                        state <= ST_RDATA;
                    end else if (expire) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_write <= bus.pwrite;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    // Slave registered prdata on the completing edge.
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_write <= 1'b0;
                    bus.rsp_rdata <= bus.prdata;
                    state <= empty ? ST_IDLE : ST_SETUP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
